// File: rtl/and_gate_pkg.sv
// Shared limits and statistics-counter constants for the and_gate_unit datapath primitive.
package and_gate_pkg;

  localparam int unsigned MAX_WIDTH  = 64;
  localparam int unsigned MAX_STAGES = 4;

  localparam int unsigned            STATS_W   = 16;
  localparam logic [STATS_W-1:0]     STATS_MAX = 16'hFFFF;

endpackage

// File: rtl/and_pipe_stage.sv
// One register stage of the and_gate_unit result pipeline: data word plus valid bit,
// synchronous active-high reset with priority over the advance enable.
module and_pipe_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      data_q  <= d;
      valid_q <= d_valid;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/and_gate_unit.sv
// Bitwise AND primitive with reduction flags and an optional registered, valid-tracked copy.
// Define AND_GATE_UNIT_STATS_EN to add the saturating all-ones hit counter (hit_count).
module and_gate_unit
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   Y,
  output logic [WIDTH-1:0]   Y_q,
  output logic               valid_q,
  output logic               all_ones,
  output logic               any_one
`ifdef AND_GATE_UNIT_STATS_EN
  ,
  output logic [STATS_W-1:0] hit_count
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || STAGES > MAX_STAGES) begin : g_param_err
    $error("and_gate_unit: illegal WIDTH=%0d or STAGES=%0d", WIDTH, STAGES);
  end

  assign Y        = A & B;
  assign all_ones = &Y;
  assign any_one  = |Y;

  // Entry 0 is the combinational result; with STAGES=0 it feeds Y_q directly.
  logic [WIDTH-1:0] pipe_data  [STAGES+1];
  logic             pipe_valid [STAGES+1];

  assign pipe_data[0]  = Y;
  assign pipe_valid[0] = 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    and_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .d       (pipe_data[k]),
      .d_valid (pipe_valid[k]),
      .q       (pipe_data[k+1]),
      .q_valid (pipe_valid[k+1])
    );
  end

  assign Y_q     = pipe_data[STAGES];
  assign valid_q = pipe_valid[STAGES];

`ifdef AND_GATE_UNIT_STATS_EN
  logic [STATS_W-1:0] hit_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
    end else if (en && all_ones && (hit_count_q != STATS_MAX)) begin
      hit_count_q <= hit_count_q + 1'b1;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_and_gate_unit.sv
// Directed self-checking bench for and_gate_unit: plain gate, 2-stage pipeline, and
// combinational pass-through configurations, plus the hit counter when it is built in.
module tb_and_gate_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // WIDTH=1, STAGES=1
  logic rst1 = 1'b1, en1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic y1, yq1, v1, ao1, an1;
  // WIDTH=8, STAGES=2
  logic       rst8 = 1'b1, en8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, y8, yq8;
  logic       v8, ao8, an8;
  // WIDTH=8, STAGES=0
  logic       rst0 = 1'b1, en0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, y0, yq0;
  logic       v0, ao0, an0;
`ifdef AND_GATE_UNIT_STATS_EN
  logic [15:0] hc1, hc8, hc0, hc4;
  logic        rst4 = 1'b1, en4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, y4, yq4;
  logic        v4, ao4, an4;
`endif

  and_gate_unit #(.WIDTH(1), .STAGES(1)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .A(a1), .B(b1), .Y(y1), .Y_q(yq1),
    .valid_q(v1), .all_ones(ao1), .any_one(an1)
`ifdef AND_GATE_UNIT_STATS_EN
    , .hit_count(hc1)
`endif
  );

  and_gate_unit #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .A(a8), .B(b8), .Y(y8), .Y_q(yq8),
    .valid_q(v8), .all_ones(ao8), .any_one(an8)
`ifdef AND_GATE_UNIT_STATS_EN
    , .hit_count(hc8)
`endif
  );

  and_gate_unit #(.WIDTH(8), .STAGES(0)) u0 (
    .clk(clk), .rst(rst0), .en(en0), .A(a0), .B(b0), .Y(y0), .Y_q(yq0),
    .valid_q(v0), .all_ones(ao0), .any_one(an0)
`ifdef AND_GATE_UNIT_STATS_EN
    , .hit_count(hc0)
`endif
  );

`ifdef AND_GATE_UNIT_STATS_EN
  and_gate_unit #(.WIDTH(4), .STAGES(1)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .A(a4), .B(b4), .Y(y4), .Y_q(yq4),
    .valid_q(v4), .all_ones(ao4), .any_one(an4), .hit_count(hc4)
  );
`endif

  // {A, B, expected Y}
  logic [2:0] vec1 [4] = '{3'b000, 3'b100, 3'b010, 3'b111};
  // {A, B, expected Y}
  logic [23:0] vec0 [3] = '{24'hF0_3C_30, 24'hAA_55_00, 24'hFF_81_81};

  initial begin
    step();
    step();
    check("w1_reset_yq", 64'(yq1), 64'h0);
    check("w1_reset_valid", 64'(v1), 64'h0);
    check("w8_reset_yq", 64'(yq8), 64'h0);
    check("w8_reset_valid", 64'(v8), 64'h0);

    // Plain gate truth table, checked right after each input change
    for (int i = 0; i < 4; i++) begin
      logic [2:0] v;
      v  = vec1[i];
      a1 = v[2];
      b1 = v[1];
      #0;
      #0;
      check($sformatf("w1_y_%0d", i), 64'(y1), 64'(v[0]));
      check($sformatf("w1_all_%0d", i), 64'(ao1), 64'(v[0]));
      check($sformatf("w1_any_%0d", i), 64'(an1), 64'(v[0]));
      #10;
    end
    a1 = 1'b0; b1 = 1'bx; #1;
    check("w1_zero_forces", 64'(y1), 64'h0);
    a1 = 1'b1; b1 = 1'bx; #1;
    check("w1_one_and_x", 64'(y1), {63'h0, 1'bx});

    // Single-stage pipeline with stall
    rst1 = 1'b0; en1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    step();
    check("w1_pipe_yq", 64'(yq1), 64'h1);
    check("w1_pipe_valid", 64'(v1), 64'h1);
    a1 = 1'b0; en1 = 1'b0;
    step();
    check("w1_hold_yq", 64'(yq1), 64'h1);
    en1 = 1'b1;
    step();
    check("w1_resume_yq", 64'(yq1), 64'h0);

    // Two-stage latency
    rst8 = 1'b0; en8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; #1;
    check("w8_y", 64'(y8), 64'h30);
    check("w8_all", 64'(ao8), 64'h0);
    check("w8_any", 64'(an8), 64'h1);
    step();
    check("w8_lat1_yq", 64'(yq8), 64'h0);
    check("w8_lat1_valid", 64'(v8), 64'h0);
    step();
    check("w8_lat2_yq", 64'(yq8), 64'h30);
    check("w8_lat2_valid", 64'(v8), 64'h1);

    // Stall with FF in stage0 and 30 at the output
    a8 = 8'hFF; b8 = 8'hFF; #1;
    check("w8_all_ff", 64'(ao8), 64'h1);
    step();
    check("w8_preload_yq", 64'(yq8), 64'h30);
    en8 = 1'b0; a8 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("w8_stall_yq_%0d", i), 64'(yq8), 64'h30);
      check($sformatf("w8_stall_valid_%0d", i), 64'(v8), 64'h1);
    end
    en8 = 1'b1;
    step();
    check("w8_resume_yq", 64'(yq8), 64'hFF);

    // Reset while the pipeline is full
    a8 = 8'hAA; b8 = 8'hFF;
    step();
    step();
    check("w8_full_yq", 64'(yq8), 64'hAA);
    rst8 = 1'b1;
    step();
    check("w8_midrst_yq", 64'(yq8), 64'h0);
    check("w8_midrst_valid", 64'(v8), 64'h0);
    rst8 = 1'b0;
    step();
    check("w8_refill1_valid", 64'(v8), 64'h0);
    step();
    check("w8_refill2_valid", 64'(v8), 64'h1);
    check("w8_refill2_yq", 64'(yq8), 64'hAA);

    // Zero-stage: combinational pass-through regardless of rst/en
    for (int i = 0; i < 3; i++) begin
      logic [23:0] v;
      v  = vec0[i];
      a0 = v[23:16];
      b0 = v[15:8];
      en0 = i[0];
      #1;
      check($sformatf("s0_y_%0d", i), 64'(y0), 64'(v[7:0]));
      check($sformatf("s0_yq_%0d", i), 64'(yq0), 64'(v[7:0]));
      step();
      check($sformatf("s0_valid_%0d", i), 64'(v0), 64'h1);
    end

`ifdef AND_GATE_UNIT_STATS_EN
    rst4 = 1'b0; en4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    step(); step(); step();
    check("hc_three", 64'(hc4), 64'd3);
    a4 = 4'h7;
    step();
    check("hc_not_all", 64'(hc4), 64'd3);
    a4 = 4'hF; en4 = 1'b0;
    step();
    check("hc_no_en", 64'(hc4), 64'd3);
    en4 = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("hc_saturate", 64'(hc4), 64'hFFFF);
    rst4 = 1'b1;
    step();
    check("hc_reset", 64'(hc4), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/and_gate_unit.md
Name: and_gate_unit

Overview:
- Bitwise 2-input AND primitive for the gate-level CPU datapath.
- Produces a combinational result `Y` immediately, plus an optional registered copy through a configurable pipeline with valid tracking.
- Also provides reduction flags (all-ones / any-one) used by flag and compare logic.
- With `WIDTH=1` and only `A`, `B`, `Y` used, it behaves as a plain AND gate.

Parameters:
- `WIDTH`, default 1: bit width of `A`, `B`, `Y`, `Y_q`; legal 1..64.
- `STAGES`, default 1: register stages on the `Y_q` path; legal 0..4.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous active-high reset, sampled on the rising edge of `clk`.
- `en` input 1: pipeline advance enable for the registered path.
- `A` input `WIDTH`: operand A.
- `B` input `WIDTH`: operand B.
- `Y` output `WIDTH`: combinational `A & B`.
- `Y_q` output `WIDTH`: `Y` delayed by `STAGES` enabled cycles.
- `valid_q` output 1: `Y_q` holds a result captured after reset.
- `all_ones` output 1: combinational `&Y`, i.e. 1 when every bit of `Y` is 1.
- `any_one` output 1: combinational `|Y`.

Behaviour:
- `Y[i] = A[i] & B[i]` for every bit, purely combinational, in the same delta/time step as any change of `A`/`B`. No dependency on `clk`, `rst` or `en`.
- X/Z handling: a 0 on either input forces that bit of `Y` to 0. Other X/Z combinations follow standard 4-state AND semantics.
- `all_ones` and `any_one` are combinational from `Y`.
  - With `WIDTH=1`, both equal `Y[0]`.
- Pipeline, `STAGES >= 1`:
  - Chain of `STAGES` registers, each `WIDTH` bits, plus a parallel chain of valid bits.
  - On a rising edge with `rst=1`: all data registers clear to 0 and all valid bits clear to 0. `rst` takes priority over `en`.
  - On a rising edge with `rst=0, en=1`: stage0 <= `Y`, valid0 <= 1, and stage k <= stage k-1 for k >= 1.
  - On a rising edge with `rst=0, en=0`: all stages and valid bits hold.
  - `Y_q` = last stage; `valid_q` = last valid bit.
  - Latency: exactly `STAGES` enabled edges from `A`/`B` sampling to `Y_q`.
- Pipeline, `STAGES = 0`:
  - `Y_q = Y` combinationally and `valid_q = 1'b1` constantly; `rst` and `en` are ignored.
- Reset mid-operation: in-flight results are discarded. `valid_q` goes low on the edge after `rst` is sampled and rises again only after `STAGES` enabled edges with `rst=0`.
- Power-up, before any reset: register contents are undefined. The bench must apply `rst` first.
- Illegal parameter values (`WIDTH<1`, `STAGES>4`) stop elaboration via a generate-time check.

Optional Feature:
- Macro: `AND_GATE_UNIT_STATS_EN`.
- When defined, adds output `hit_count` [15:0]:
  - Counts rising edges with `rst=0`, `en=1` and `all_ones=1`.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by synchronous `rst`.
- When undefined:
  - The port does not exist.
  - No counter logic is instantiated.
  - All other behaviour is identical.

Decomposition:
- Shared package `and_gate_pkg` holds:
  - `MAX_WIDTH=64` and `MAX_STAGES=4`.
  - `STATS_W=16` and `STATS_MAX=16'hFFFF`.
- Natural sub-module: `and_pipe_stage`, one `WIDTH`-bit data register plus valid bit with sync reset and enable. Instantiate it `STAGES` times in a generate loop.
- The combinational AND and the reductions stay in the top module.

Test Plan:
- `WIDTH=1`, drive `A/B` = 00, 10, 01, 11, 10 time units apart -> `Y` = 0, 0, 0, 1 in the same time step as each change; `all_ones`/`any_one` track `Y`.
- `WIDTH=8, STAGES=2`: assert `rst` for 2 edges, then `A=8'hF0, B=8'h3C, en=1` -> `Y=8'h30` immediately; `Y_q=8'h30` with `valid_q=1` after the 2nd enabled edge; `Y_q=0, valid_q=0` before that.
- Enable stall: `STAGES=2`, load `8'hFF&8'hFF`, drop `en` for 3 edges -> `Y_q` and `valid_q` frozen. Raise `en` -> pipeline resumes, total latency of 2 enabled edges.
- Reset mid-flight: pipeline full with `8'hAA`, assert `rst` for one edge with `en=1` -> `Y_q=0, valid_q=0` next edge. `valid_q` returns after 2 enabled edges.
- `STAGES=0`: toggle `A/B` with `rst=1` held -> `Y_q` equals `Y` combinationally, `valid_q=1`.
- With `AND_GATE_UNIT_STATS_EN` and `WIDTH=4`: hold `A=B=4'hF, en=1` for 70000 edges -> `hit_count=16'hFFFF` (saturated); `rst` -> 0.
